// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the requesters and the register-file arbiter.
// The arbiter takes the slave view; requesters take the master view.
interface regfile_write_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 3,
    parameter int DW   = 16,
    parameter int CW   = 16
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic               we_en;
    logic [AW-1:0]      we_addr;
    logic [DW-1:0]      we_data;
    logic               busy;
    logic [CW-1:0]      wr_count;

    modport master (
        output req, req_addr, req_data,
        input  gnt, we_en, we_addr, we_data, busy, wr_count
    );

    modport slave (
        input  req, req_addr, req_data,
        output gnt, we_en, we_addr, we_data, busy, wr_count
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port.
// Define REGFILE_ARB_R0_PROTECT_EN to make register 0 read-only.
module regfile_write_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 3,
    parameter int DW   = 16,
    parameter int CW   = 16
) (
    input logic clk,
    input logic reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);
    localparam logic [PW:0] NR = (PW+1)'(NREQ);

    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] elig;
    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   win_next;
    logic [NREQ-1:0] win_oh;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;
    logic            win_commit;
    logic [PW:0]     scan;

    // A requester granted this cycle may still show req high, so skip it.
    assign elig = bus.req & ~bus.gnt;

    // Scan from ptr upward with wrap modulo NREQ; first eligible wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr} + (PW+1)'(k);
            if (scan >= NR) scan = scan - NR;
            if (!win_found && elig[scan[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[PW-1:0];
            end
        end
    end

    // Select the winner's address/data and derive the next pointer.
    always_comb begin
        win_addr = '0;
        win_data = '0;
        win_oh   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == win_idx) begin
                win_addr  = bus.req_addr[i*AW +: AW];
                win_data  = bus.req_data[i*DW +: DW];
                win_oh[i] = 1'b1;
            end
        end
        win_next = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
    end

`ifdef REGFILE_ARB_R0_PROTECT_EN
    assign win_commit = win_found && (win_addr != '0);
`else
    assign win_commit = win_found;
`endif

    assign bus.busy = (|bus.req) | bus.we_en;

    // Register the grant, write-port outputs, pointer and commit count.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.gnt      <= '0;
            bus.we_en    <= 1'b0;
            bus.we_addr  <= '0;
            bus.we_data  <= '0;
            bus.wr_count <= '0;
            ptr          <= '0;
        end else begin
            bus.gnt   <= win_found ? win_oh : '0;
            bus.we_en <= win_commit;
            if (win_found) begin
                bus.we_addr <= win_addr;
                bus.we_data <= win_data;
                ptr         <= win_next;
            end
            if (bus.we_en && bus.wr_count != '1)
                bus.wr_count <= bus.wr_count + CW'(1);
        end
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 8-entry register file among NREQ requesters using round-robin arbitration.
- Registered outputs we_addr and we_en drive the 3-to-8 write-select decoder inputs (data, enable) directly.
- we_data drives the register file data-in bus.
- Sustains one committed write per clock while distinct requesters are pending.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 3, register address width; matches the decoder select width.
- DW, 16, register data width.
- CW, 16, width of the committed-write counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester write request, level-held until granted.
- req_addr  input  NREQ*AW  packed target addresses; requester i occupies bits [i*AW +: AW].
- req_data  input  NREQ*DW  packed write data; requester i occupies bits [i*DW +: DW].
- gnt  output  NREQ  registered one-hot grant, one-cycle pulse per served request.
- we_en  output  1  registered write enable to the decoder enable input.
- we_addr  output  AW  registered write address to the decoder data input.
- we_data  output  DW  registered write data to the register file.
- busy  output  1  combinational; high when any req bit is set or we_en is high.
- wr_count  output  CW  count of committed writes (we_en high cycles); saturates at all-ones.

Behaviour:
- Reset (reset=1 at a clk edge): gnt=0, we_en=0, we_addr=0, we_data=0, wr_count=0, round-robin pointer ptr=0.
  - Any grant in flight is discarded; no write commits in the cycle following reset.
- Arbitration happens every clk edge over the eligible set = req AND NOT gnt.
  - The requester granted in cycle t is excluded at the edge ending cycle t, because its req may still read high while it reacts.
- Winner is the first eligible index scanning ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1 (modulo NREQ).
- When a winner w exists, at the next edge:
  - gnt = one-hot(w), we_en=1.
  - we_addr = req_addr slice w, we_data = req_data slice w, captured in the same edge.
  - ptr = (w+1) mod NREQ.
- When no requester is eligible: gnt=0, we_en=0, and we_addr/we_data/ptr hold their values.
- Latency: req asserted at edge k (eligible) → gnt/we_en high during cycle k+1. The register file commits at edge k+2.
- Requester protocol:
  - Hold req, req_addr and req_data stable until gnt is seen.
  - In the cycle gnt is high, either drop req or present a new address/data. A req still high after that cycle is a new request.
- A single continuous requester is served every other cycle (a consequence of the exclusion rule).
- wr_count increments by 1 on each edge where we_en=1, and stops at 2^CW-1.
- Changes to req_addr/req_data of a non-granted requester have no effect.
- Out-of-range ptr cannot occur; ptr width is ceil(log2(NREQ)), and the wrap computation is modulo NREQ, not power of two.
- Duplicate addresses from different requesters in consecutive cycles both commit, in grant order; the last write wins.

Optional Feature:
- Macro REGFILE_ARB_R0_PROTECT_EN.
- Defined (register 0 treated as read-only):
  - A winning request with address 0 still receives its gnt pulse and consumes its round-robin turn.
  - we_en stays 0 that cycle and wr_count does not increment.
  - we_addr/we_data still load the request's values.
- Undefined: address 0 is an ordinary writable register.

Test Plan:
1. reset=1 for 2 cycles with req=4'b1111 → gnt=0, we_en=0, wr_count=0 throughout; first gnt=4'b0001 appears 1 cycle after reset deasserts.
2. req=4'b1111 held; addr i = i+1, data i = 16'hA000+i → gnt sequence 0001,0010,0100,1000,0001. we_addr 1,2,3,4,1 with we_en=1 every cycle; wr_count=5 after 5 cycles.
3. Only req[2] held high continuously → gnt alternates 0100,0000,0100; we_en toggles 1,0,1.
4. ptr at 3, then req=4'b0011 → gnt=0001 first, then 0010. Index 0 wins because of the wrap from ptr=3.
5. reset asserted in the cycle after req[1] becomes eligible → no gnt[1] pulse, we_en=0, ptr=0; wr_count stays 0.
6. Macro defined, req[0] with addr=0, data=16'hFFFF → gnt=0001 pulse, we_en=0, wr_count unchanged. Macro undefined, same stimulus → we_en=1, we_addr=0, wr_count+1.
